// File: rtl/fetch_stream_pkg.sv
// Shared types and elaboration helpers for the fetch_stream front-end.
package fetch_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int SYMS_PER_WORD = 32 / 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int syms_per_word(input int word_w, input int sym_w);
    return word_w / sym_w;
  endfunction

endpackage

// File: rtl/sync_fifo_w.sv
// Single-clock FIFO of parametric width with occupancy count and synchronous flush.
module sync_fifo_w
  import fetch_stream_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 512,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          wr_ok_s;
  logic          rd_ok_s;

  always_comb begin
    empty   = (count_r == '0);
    wr_ok_s = wr_en && (count_r != CNT_FULL);
    rd_ok_s = rd_en && !empty;
    rd_data = mem_r[rd_ptr_r];
    count   = count_r;
  end

  // storage array carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stream.sv
// Credit-based word fetcher: issues sequential reads, buffers responses, unpacks words into symbols.
module fetch_stream
  import fetch_stream_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int SYM_W   = 8,
  parameter int DEPTH   = 512,
  parameter int MAX_OUT = 4,
  localparam int LVL_W  = clog2(DEPTH) + 1
) (
  input  logic              CCLK,
  input  logic              CRST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W-1:0] LEN_WORDS,
  input  logic              ABORT,
  output logic              REQ_VALID,
  output logic [ADDR_W-1:0] REQ_ADDR,
  input  logic              REQ_READY,
  input  logic              RSP_VALID,
  input  logic [WORD_W-1:0] RSP_DATA,
  output logic              O_VALID,
  output logic [SYM_W-1:0]  O_DATA,
  output logic              O_LAST,
  input  logic              O_READY,
  output logic              BUSY,
  output logic              DONE,
  output logic [LVL_W-1:0]  LEVEL
);

  localparam int SPW   = syms_per_word(WORD_W, SYM_W);
  localparam int IDX_W = (SPW > 1) ? clog2(SPW) : 1;
  localparam int OUT_W = clog2(MAX_OUT + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SPW - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1'b1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_W / 8);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);

  if (DEPTH < MAX_OUT || (WORD_W % SYM_W) != 0) begin : g_param_check
    $error("fetch_stream: need DEPTH >= MAX_OUT and WORD_W a multiple of SYM_W");
  end

  state_t              state_r, state_nx_s;
  logic [ADDR_W-1:0]   req_addr_r, remaining_r, words_left_r;
  logic                bounded_r;
  logic [OUT_W-1:0]    outstanding_r, discard_r, out_nx_s;
  logic [WORD_W-1:0]   sh_r;
  logic [IDX_W-1:0]    idx_r;
  logic                hold_r, last_word_r;
  logic [WORD_W-1:0]   fifo_rd_s;
  logic                fifo_empty_s;
  logic [LVL_W-1:0]    fifo_count_s;
  logic [31:0]         credit_sum_s;
  logic                req_valid_s, accept_s, rsp_take_s, rsp_drop_s, start_ok_s;
  logic                sym_acc_s, last_sym_s, o_last_s, load_s;

  sync_fifo_w #(.W(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (CCLK),
    .rst     (CRST),
    .flush   (ABORT),
    .wr_en   (rsp_take_s),
    .wr_data (RSP_DATA),
    .rd_en   (load_s),
    .rd_data (fifo_rd_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // credit check, handshakes and unpack control decode
  always_comb begin
    credit_sum_s = 32'(fifo_count_s) + 32'(outstanding_r) + 32'(hold_r);
    req_valid_s  = (state_r == S_RUN) && (credit_sum_s < 32'(DEPTH))
                   && (32'(outstanding_r) < 32'(MAX_OUT));
    accept_s     = req_valid_s && REQ_READY;
    rsp_take_s   = RSP_VALID && (|outstanding_r);
    rsp_drop_s   = RSP_VALID && !(|outstanding_r) && (|discard_r);
    out_nx_s     = outstanding_r + OUT_W'(accept_s) - OUT_W'(rsp_take_s);
    start_ok_s   = START && !ABORT && !(|discard_r)
                   && ((state_r == S_IDLE) || (state_r == S_DONE));
    sym_acc_s    = hold_r && O_READY;
    last_sym_s   = hold_r && (idx_r == IDX_LAST);
    o_last_s     = last_sym_s && last_word_r;
    load_s       = !fifo_empty_s && (!hold_r || (sym_acc_s && last_sym_s));
  end

  // next-state selection; ABORT overrides everything
  always_comb begin
    state_nx_s = state_r;
    if (ABORT) begin
      state_nx_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:  if (start_ok_s) state_nx_s = S_RUN; else state_nx_s = S_IDLE;
        S_RUN:   if (accept_s && bounded_r && remaining_r == ADDR_ONE) state_nx_s = S_DRAIN;
                 else state_nx_s = S_RUN;
        S_DRAIN: if (!(|outstanding_r) && fifo_empty_s && sym_acc_s && o_last_s) state_nx_s = S_DONE;
                 else state_nx_s = S_DRAIN;
        S_DONE:  if (start_ok_s) state_nx_s = S_RUN; else state_nx_s = S_DONE;
        default: state_nx_s = S_IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge CCLK) begin
    if (CRST) state_r <= S_IDLE;
    else      state_r <= state_nx_s;
  end

  // request address, run length and in-flight / discard accounting
  always_ff @(posedge CCLK) begin
    if (CRST) begin
      req_addr_r    <= '0;
      remaining_r   <= '0;
      bounded_r     <= 1'b0;
      outstanding_r <= '0;
      discard_r     <= '0;
    end else begin
      if (start_ok_s) begin
        req_addr_r  <= BASE_ADDR;
        remaining_r <= LEN_WORDS;
        bounded_r   <= |LEN_WORDS;
      end else if (accept_s) begin
        req_addr_r  <= req_addr_r + ADDR_STEP;
        if (bounded_r) remaining_r <= remaining_r - ADDR_ONE;
      end
      // on ABORT every request still in flight turns into a response to drop
      if (ABORT) begin
        outstanding_r <= '0;
        discard_r     <= discard_r - OUT_W'(rsp_drop_s) + out_nx_s;
      end else begin
        outstanding_r <= out_nx_s;
        discard_r     <= discard_r - OUT_W'(rsp_drop_s);
      end
    end
  end

  // unpack register: shifts right so the current symbol is always the low slice
  always_ff @(posedge CCLK) begin
    if (CRST) begin
      sh_r         <= '0;
      idx_r        <= '0;
      hold_r       <= 1'b0;
      last_word_r  <= 1'b0;
      words_left_r <= '0;
    end else if (ABORT) begin
      sh_r        <= '0;
      idx_r       <= '0;
      hold_r      <= 1'b0;
      last_word_r <= 1'b0;
    end else if (start_ok_s) begin
      words_left_r <= LEN_WORDS;
    end else if (load_s) begin
      sh_r        <= fifo_rd_s;
      idx_r       <= '0;
      hold_r      <= 1'b1;
      last_word_r <= bounded_r && (words_left_r == ADDR_ONE);
      if (bounded_r) words_left_r <= words_left_r - ADDR_ONE;
    end else if (sym_acc_s) begin
      if (last_sym_s) begin
        hold_r <= 1'b0;
      end else begin
        sh_r  <= sh_r >> SYM_W;
        idx_r <= idx_r + IDX_ONE;
      end
    end
  end

  assign REQ_VALID = req_valid_s;
  assign REQ_ADDR  = req_addr_r;
  assign O_VALID   = hold_r;
  assign O_DATA    = sh_r[SYM_W-1:0];
  assign O_LAST    = o_last_s;
  assign BUSY      = (state_r == S_RUN) || (state_r == S_DRAIN);
  assign DONE      = (state_r == S_DONE);
  assign LEVEL     = fifo_count_s;

endmodule

// File: tb/tb_fetch_stream.sv
// Scoreboard bench for fetch_stream: a fetch-unit model answers requests, a monitor checks symbols.
`timescale 1ns/1ps
module tb_fetch_stream;
  import fetch_stream_pkg::*;

  logic        CCLK = 1'b0, CRST = 1'b1, START = 1'b0, ABORT = 1'b0;
  logic        REQ_READY = 1'b0, RSP_VALID = 1'b0, O_READY = 1'b0;
  logic [31:0] BASE_ADDR = 32'h0, LEN_WORDS = 32'h0, RSP_DATA = 32'h0;
  logic        REQ_VALID, O_VALID, O_LAST, BUSY, DONE;
  logic [31:0] REQ_ADDR;
  logic [7:0]  O_DATA;
  logic [4:0]  LEVEL;

  int total = 0, bad = 0, acc_cnt = 0, last_cnt = 0;
  bit rsp_pause = 1'b0;
  logic [31:0] pend[$];
  logic [8:0]  exp_sym[$];
  logic [31:0] exp_addr[$];

  fetch_stream #(.ADDR_W(32), .WORD_W(32), .SYM_W(8), .DEPTH(16), .MAX_OUT(4)) dut (
    .CCLK(CCLK), .CRST(CRST), .START(START), .BASE_ADDR(BASE_ADDR), .LEN_WORDS(LEN_WORDS),
    .ABORT(ABORT), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .REQ_READY(REQ_READY),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .O_VALID(O_VALID), .O_DATA(O_DATA),
    .O_LAST(O_LAST), .O_READY(O_READY), .BUSY(BUSY), .DONE(DONE), .LEVEL(LEVEL)
  );

  always #5 CCLK = ~CCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h100)      return 32'h4433_2211;
    else if (a == 32'h104) return 32'h8877_6655;
    else                   return {~a[15:0], a[15:0]} ^ 32'h0F1E_2D3C;
  endfunction

  task automatic push_word(input logic [31:0] a, input bit last);
    logic [31:0] w;
    w = data_of(a);
    exp_addr.push_back(a);
    for (int i = 0; i < 4; i++) exp_sym.push_back({last && (i == 3), w[i*8 +: 8]});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CCLK);
    #1;
  endtask

  task automatic start_run(input logic [31:0] base, input logic [31:0] len);
    BASE_ADDR = base; LEN_WORDS = len; START = 1'b1;
    cyc(1);
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!DONE && n < budget) begin cyc(1); n++; end
    check(name, DONE, 1);
  endtask

  // fetch-unit model: one-cycle response latency, responses in request order
  initial forever begin
    @(negedge CCLK);
    if (CRST) pend.delete();
    else if (REQ_VALID && REQ_READY) begin
      pend.push_back(data_of(REQ_ADDR));
      acc_cnt++;
    end
    @(posedge CCLK); #1;
    if (!CRST && !rsp_pause && pend.size() > 0) begin
      RSP_VALID = 1'b1;
      RSP_DATA  = pend.pop_front();
    end else begin
      RSP_VALID = 1'b0;
    end
  end

  // monitor: symbol and address scoreboard plus hold-while-stalled check
  initial begin
    logic       pv;
    logic [7:0] pd;
    logic [8:0] e;
    pv = 1'b0; pd = 8'h0;
    forever begin
      @(negedge CCLK);
      if (CRST) pv = 1'b0;
      else begin
        if (pv) begin
          check("hold_valid", O_VALID, 1);
          check("hold_data", O_DATA, pd);
        end
        if (O_VALID && O_READY) begin
          if (O_LAST) last_cnt++;
          if (exp_sym.size() == 0) begin
            total++; bad++;
            $display("FAIL sym_extra: got %0h expected no symbol", O_DATA);
          end else begin
            e = exp_sym.pop_front();
            check("sym_data", O_DATA, e[7:0]);
            check("sym_last", O_LAST, e[8]);
          end
        end
        pv = O_VALID && !O_READY && !ABORT;
        pd = O_DATA;
        if (REQ_VALID && REQ_READY && exp_addr.size() > 0) check("req_addr", REQ_ADDR, exp_addr.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  t1 [8];
    logic [31:0] w;
    int a0, lc0, n;
    bit ov;
    t1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    cyc(3);
    check("rst_ctrl", {REQ_VALID, O_VALID, O_LAST, BUSY, DONE}, 5'b0);
    check("rst_addr", REQ_ADDR, 0);
    check("rst_data_level", {O_DATA, LEVEL}, 0);
    CRST = 1'b0;
    cyc(1);

    // 1: bounded two-word run with hand-computed symbols
    REQ_READY = 1'b1; O_READY = 1'b1;
    exp_addr.push_back(32'h100); exp_addr.push_back(32'h104);
    for (int i = 0; i < 8; i++) exp_sym.push_back({i == 7, t1[i]});
    start_run(32'h100, 32'h2);
    check("t1_busy", BUSY, 1);
    wait_done(100, "t1_done");
    check("t1_syms_left", exp_sym.size(), 0);
    check("t1_last_cnt", last_cnt, 1);

    // 2: unbounded, consumer stalled; one word parks in the unpack register
    O_READY = 1'b0; a0 = acc_cnt;
    start_run(32'h200, 32'h0);
    cyc(60);
    check("t2_req_valid", REQ_VALID, 0);
    check("t2_accepts", acc_cnt - a0, 16);
    check("t2_level", LEVEL, 15);
    check("t2_hold_sym", {O_VALID, O_DATA}, {1'b1, 8'h3C});
    ABORT = 1'b1; cyc(1); ABORT = 1'b0;
    check("t2_abort", {BUSY, O_VALID, LEVEL}, 0);

    // 3: request held under back-pressure
    O_READY = 1'b1; REQ_READY = 1'b0; a0 = acc_cnt;
    push_word(32'h300, 1'b1);
    start_run(32'h300, 32'h1);
    for (int i = 0; i < 5; i++) begin
      check("t3_addr_hold", {REQ_VALID, REQ_ADDR}, {1'b1, 32'h300});
      cyc(1);
    end
    REQ_READY = 1'b1;
    wait_done(50, "t3_done");
    check("t3_one_accept", acc_cnt - a0, 1);

    // 4: abort with three in flight, STARTs blocked until they are discarded
    REQ_READY = 1'b0; rsp_pause = 1'b1; a0 = acc_cnt;
    start_run(32'h400, 32'h0);
    REQ_READY = 1'b1; cyc(3); REQ_READY = 1'b0;
    check("t4_accepts", acc_cnt - a0, 3);
    BASE_ADDR = 32'h500; LEN_WORDS = 32'h1;
    ABORT = 1'b1; START = 1'b1; cyc(1);
    ABORT = 1'b0; cyc(1); START = 1'b0;
    check("t4_starts_ignored", {BUSY, DONE, REQ_VALID}, 0);
    rsp_pause = 1'b0; START = 1'b1; cyc(1); START = 1'b0;
    check("t4_start_in_discard", BUSY, 0);
    ov = 1'b0;
    for (int i = 0; i < 8; i++) begin ov |= O_VALID; cyc(1); end
    check("t4_no_output", ov, 0);
    check("t4_level", LEVEL, 0);

    // 5: 64-word run against a randomly stalling consumer
    REQ_READY = 1'b1; lc0 = last_cnt;
    for (int i = 0; i < 64; i++) push_word(32'h1000 + 32'(i * 4), i == 63);
    start_run(32'h1000, 32'd64);
    n = 0;
    while (!DONE && n < 3000) begin O_READY = 1'($urandom_range(0, 1)); cyc(1); n++; end
    O_READY = 1'b1;
    check("t5_done", DONE, 1);
    check("t5_last_once", last_cnt - lc0, 1);
    check("t5_syms_left", exp_sym.size(), 0);
    check("t5_addrs_left", exp_addr.size(), 0);

    // 6: reset while the second symbol of a word is presented
    w = data_of(32'h2000);
    exp_sym.push_back({1'b0, w[7:0]});
    start_run(32'h2000, 32'h4);
    n = 0;
    while (!O_VALID && n < 50) begin cyc(1); n++; end
    check("t6_first_valid", O_VALID, 1);
    cyc(1); O_READY = 1'b0;
    check("t6_second_sym", O_DATA, w[15:8]);
    CRST = 1'b1; cyc(1);
    check("t6_ctrl", {REQ_VALID, O_VALID, O_LAST, BUSY, DONE}, 5'b0);
    check("t6_data", {REQ_ADDR, O_DATA, LEVEL}, 0);
    check("t6_state", dut.state_r, S_IDLE);
    CRST = 1'b0; cyc(2);
    check("t6_syms_left", exp_sym.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
